// File: rtl/tans_hf_decoder_if.sv
// Serial stream bundle for the tANS-to-Huffman decoder:
// refill bits in (i_*) and Huffman code bits out (o_*).
interface tans_hf_decoder_if;
  logic i_bit;
  logic i_valid;
  logic i_ready;
  logic o_bit;
  logic o_valid;
  logic o_ready;
  logic o_last;

  modport master (
    output i_bit, i_valid, o_ready,
    input  i_ready, o_bit, o_valid, o_last
  );

  modport slave (
    input  i_bit, i_valid, o_ready,
    output i_ready, o_bit, o_valid, o_last
  );
endinterface

// File: rtl/tans_hf_decoder.sv
// tANS (L=8: A:5 B:2 C:1) to Huffman (A=0 B=10 C=11) decoder.
// Optional TANS_DEC_ERR_EN: flag and skip start states below 8.
module tans_hf_decoder #(
  parameter int COUNT_W = 8
) (
  input  logic               PHI,
  input  logic               RST,
  input  logic               START,
  input  logic [3:0]         i_state,
  input  logic [COUNT_W-1:0] i_count,
  tans_hf_decoder_if.slave   io,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, EMIT, READ, FIN
  } st_t;

  typedef enum logic [1:0] {
    SYM_A, SYM_B, SYM_C
  } sym_t;

  st_t                st, st_n;
  sym_t               sym, sym_n, t_sym;
  logic [3:0]         x, x_n, xs, xs_n, t_xs, ld;
  logic [1:0]         nb, nb_n, t_nb;
  logic [COUNT_W-1:0] cnt, cnt_n;
  logic               cb, cb_n;
  logic               ov, ov_n, ob, ob_n, ol, ol_n;
  logic               ir, ir_n;
  logic               err_start;
`ifdef TANS_DEC_ERR_EN
  logic               err, err_n;
  assign ld        = i_state;
  assign err_start = ~i_state[3];
  assign ERR       = err;
`else
  assign ld        = i_state | 4'b1000;
  assign err_start = 1'b0;
  assign ERR       = 1'b0;
`endif

  assign BUSY       = (st != IDLE);
  assign DONE       = (st == FIN);
  assign io.o_valid = ov;
  assign io.o_bit   = ob;
  assign io.o_last  = ol;
  assign io.i_ready = ir;

  // Decode table: x -> symbol, x_s, refill bit count
  always_comb begin
    t_sym = SYM_A;
    t_xs  = x - 4'd3;
    t_nb  = 2'd0;
    unique case (1'b1)
      (x >= 4'd8 && x <= 4'd10): t_nb = 2'd1;
      (x == 4'd11 || x == 4'd12): t_nb = 2'd0;
      (x == 4'd13 || x == 4'd14): begin
        t_sym = SYM_B;
        t_xs  = x - 4'd11;
        t_nb  = 2'd2;
      end
      (x == 4'd15): begin
        t_sym = SYM_C;
        t_xs  = 4'd1;
        t_nb  = 2'd3;
      end
      default: t_nb = 2'd0;
    endcase
  end

  always_comb begin
    st_n  = st;
    x_n   = x;
    xs_n  = xs;
    nb_n  = nb;
    sym_n = sym;
    cnt_n = cnt;
    cb_n  = cb;
    ov_n  = ov;
    ob_n  = ob;
    ol_n  = ol;
    ir_n  = ir;
`ifdef TANS_DEC_ERR_EN
    err_n = err;
`endif
    unique case (st)
      IDLE: begin
        if (START) begin
          x_n   = ld;
          cnt_n = i_count;
`ifdef TANS_DEC_ERR_EN
          err_n = err_start;
`endif
          if (err_start || i_count == '0)
            st_n = FIN;
          else
            st_n = LOOKUP;
        end
      end
      LOOKUP: begin
        sym_n = t_sym;
        xs_n  = t_xs;
        nb_n  = t_nb;
        if (cnt != '0)
          cnt_n = cnt - 1'b1;
        cb_n  = 1'b0;
        ov_n  = 1'b1;
        ob_n  = (t_sym != SYM_A);
        ol_n  = (cnt == COUNT_W'(1)) && (t_sym == SYM_A);
        st_n  = EMIT;
      end
      EMIT: begin
        if (ov && io.o_ready) begin
          if (sym != SYM_A && !cb) begin
            cb_n = 1'b1;
            ob_n = (sym == SYM_C);
            ol_n = (cnt == '0);
          end else begin
            ov_n = 1'b0;
            ob_n = 1'b0;
            ol_n = 1'b0;
            // last symbol: remaining state is dropped
            if (cnt == '0) begin
              st_n = FIN;
            end else if (nb == 2'd0) begin
              x_n  = xs;
              st_n = LOOKUP;
            end else begin
              ir_n = 1'b1;
              st_n = READ;
            end
          end
        end
      end
      READ: begin
        if (ir && io.i_valid) begin
          xs_n = {xs[2:0], io.i_bit};
          nb_n = nb - 2'd1;
          if (nb == 2'd1) begin
            ir_n = 1'b0;
            x_n  = {xs[2:0], io.i_bit};
            st_n = LOOKUP;
          end
        end
      end
      FIN:     st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge PHI or posedge RST) begin
    if (RST) begin
      st  <= IDLE;
      x   <= '0;
      xs  <= '0;
      nb  <= '0;
      sym <= SYM_A;
      cnt <= '0;
      cb  <= 1'b0;
      ov  <= 1'b0;
      ob  <= 1'b0;
      ol  <= 1'b0;
      ir  <= 1'b0;
`ifdef TANS_DEC_ERR_EN
      err <= 1'b0;
`endif
    end else begin
      st  <= st_n;
      x   <= x_n;
      xs  <= xs_n;
      nb  <= nb_n;
      sym <= sym_n;
      cnt <= cnt_n;
      cb  <= cb_n;
      ov  <= ov_n;
      ob  <= ob_n;
      ol  <= ol_n;
      ir  <= ir_n;
`ifdef TANS_DEC_ERR_EN
      err <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_tans_hf_decoder.sv
// Bench for tans_hf_decoder: directed table, stall/reset/error
// sequences, and random runs against a behavioural decode model.
module tb_tans_hf_decoder;

  logic       PHI = 1'b0;
  logic       RST;
  logic       START;
  logic [3:0] i_state;
  logic [7:0] i_count;
  logic       BUSY, DONE, ERR;

  tans_hf_decoder_if io();

  tans_hf_decoder #(.COUNT_W(8)) dut (
    .PHI(PHI),
    .RST(RST),
    .START(START),
    .i_state(i_state),
    .i_count(i_count),
    .io(io),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERR(ERR)
  );

  initial forever #5 PHI = ~PHI;

  typedef struct {
    logic [3:0] st;
    int         cnt;
    int         nsrc;
    logic [7:0] src;
    int         nexp;
    logic [7:0] expv;
  } vec_t;

  vec_t tbl[12];
  int   ntbl;
  bit   src[64];
  bit   expo[64];
  int   nexp, nused;
  int   oi, bi;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: decode from the table rules, refilling until x_s >= 8
  task automatic model(input int st, input int cnt);
    int x, xs;
    x = st;
    nexp = 0;
    nused = 0;
    for (int k = 0; k < cnt; k++) begin
      if (x >= 8 && x <= 12) begin
        expo[nexp++] = 1'b0;
        xs = x - 3;
      end else if (x <= 14) begin
        expo[nexp++] = 1'b1;
        expo[nexp++] = 1'b0;
        xs = x - 11;
      end else begin
        expo[nexp++] = 1'b1;
        expo[nexp++] = 1'b1;
        xs = 1;
      end
      if (k == cnt - 1) break;
      while (xs < 8) begin
        xs = xs * 2 + int'(src[nused]);
        nused++;
      end
      x = xs;
    end
  endtask

  task automatic start(input logic [3:0] s, input int c);
    START   = 1'b1;
    i_state = s;
    i_count = c[7:0];
    @(negedge PHI);
    START = 1'b0;
    oi = 0;
    bi = 0;
  endtask

  task automatic drive(input bit rnd, input int cnt);
    int cyc, busy;
    bit done;
    cyc = 0;
    busy = 0;
    done = 0;
    while (!done && cyc < 3000) begin
      io.i_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      io.o_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      io.i_bit   = (bi < 64) ? src[bi] : 1'b0;
      if (BUSY) busy++;
      if (io.i_ready && io.o_valid) chk("excl", 1, 0);
      if (io.o_valid && io.o_ready) begin
        if (oi < nexp) begin
          chk("obit", int'(io.o_bit), int'(expo[oi]));
          chk("olast", int'(io.o_last), int'(oi == nexp - 1));
        end else begin
          chk("extra_bit", oi, nexp - 1);
        end
        oi++;
      end
      if (io.i_ready && io.i_valid) bi++;
      if (DONE) done = 1;
      @(negedge PHI);
      cyc++;
    end
    io.i_valid = 1'b0;
    io.o_ready = 1'b0;
    chk("done_seen", int'(done), 1);
    chk("n_out", oi, nexp);
    chk("n_in", bi, nused);
    if (!rnd && cnt >= 0)
      chk("cycles", busy, cnt + nexp + nused + 1);
    chk("busy_after", int'(BUSY), 0);
    chk("done_after", int'(DONE), 0);
  endtask

  task automatic run_vec(input int i);
    for (int k = 0; k < 64; k++) src[k] = 1'b0;
    for (int k = 0; k < tbl[i].nsrc; k++)
      src[k] = tbl[i].src[tbl[i].nsrc - 1 - k];
    for (int k = 0; k < tbl[i].nexp; k++)
      expo[k] = tbl[i].expv[tbl[i].nexp - 1 - k];
    nexp  = tbl[i].nexp;
    nused = tbl[i].nsrc;
    start(tbl[i].st, tbl[i].cnt);
    drive(1'b0, tbl[i].cnt);
  endtask

  initial begin
    int w;
    int rs, rc;

    tbl[0] = '{4'd8,  1, 0, 8'b0,   1, 8'b0};
    tbl[1] = '{4'd13, 2, 2, 8'b11,  3, 8'b100};
    tbl[2] = '{4'd15, 2, 3, 8'b001, 3, 8'b110};
    tbl[3] = '{4'd14, 1, 0, 8'b0,   2, 8'b10};
    tbl[4] = '{4'd15, 1, 0, 8'b0,   2, 8'b11};
    tbl[5] = '{4'd10, 2, 1, 8'b1,   3, 8'b011};
    tbl[6] = '{4'd12, 2, 0, 8'b0,   2, 8'b00};
    tbl[7] = '{4'd8,  0, 0, 8'b0,   0, 8'b0};
    tbl[8] = '{4'd8,  3, 1, 8'b1,   3, 8'b000};
    tbl[9] = '{4'd13, 3, 3, 8'b011, 5, 8'b10010};
    ntbl = 10;
`ifndef TANS_DEC_ERR_EN
    tbl[10] = '{4'd3, 1, 0, 8'b0, 1, 8'b0};
    ntbl = 11;
`endif

    RST = 1'b1;
    START = 1'b0;
    i_state = '0;
    i_count = '0;
    io.i_bit = 1'b0;
    io.i_valid = 1'b0;
    io.o_ready = 1'b0;
    repeat (2) @(negedge PHI);
    chk("rst_i_ready", int'(io.i_ready), 0);
    chk("rst_o_bit", int'(io.o_bit), 0);
    chk("rst_o_valid", int'(io.o_valid), 0);
    chk("rst_o_last", int'(io.o_last), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_err", int'(ERR), 0);
    RST = 1'b0;
    @(negedge PHI);

    for (int i = 0; i < ntbl; i++) run_vec(i);

    // o_ready held low after the first code bit appears
    start(4'd9, 2);
    w = 0;
    while (!io.o_valid && w < 10) begin
      @(negedge PHI);
      w++;
    end
    chk("stall_ov_seen", int'(io.o_valid), 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_ov", int'(io.o_valid), 1);
      chk("stall_obit", int'(io.o_bit), 0);
      chk("stall_olast", int'(io.o_last), 0);
      @(negedge PHI);
    end
    src[0] = 1'b1;
    expo[0] = 1'b0;
    expo[1] = 1'b1;
    expo[2] = 1'b0;
    nexp = 3;
    nused = 1;
    drive(1'b0, -1);

    // asynchronous reset while waiting in READ
    src[0] = 1'b1;
    io.o_ready = 1'b1;
    io.i_valid = 1'b0;
    start(4'd13, 3);
    w = 0;
    while (!io.i_ready && w < 20) begin
      @(negedge PHI);
      w++;
    end
    chk("read_seen", int'(io.i_ready), 1);
    RST = 1'b1;
    #1;
    chk("arst_i_ready", int'(io.i_ready), 0);
    chk("arst_o_valid", int'(io.o_valid), 0);
    chk("arst_o_bit", int'(io.o_bit), 0);
    chk("arst_o_last", int'(io.o_last), 0);
    chk("arst_busy", int'(BUSY), 0);
    chk("arst_done", int'(DONE), 0);
    @(negedge PHI);
    RST = 1'b0;
    io.o_ready = 1'b0;
    @(negedge PHI);
    run_vec(1);

`ifdef TANS_DEC_ERR_EN
    io.o_ready = 1'b1;
    io.i_valid = 1'b1;
    start(4'd3, 2);
    chk("err_set", int'(ERR), 1);
    chk("err_done", int'(DONE), 1);
    chk("err_o_valid", int'(io.o_valid), 0);
    chk("err_i_ready", int'(io.i_ready), 0);
    @(negedge PHI);
    chk("err_sticky", int'(ERR), 1);
    chk("err_idle", int'(BUSY), 0);
    io.o_ready = 1'b0;
    io.i_valid = 1'b0;
    run_vec(0);
    chk("err_clear", int'(ERR), 0);
`endif

    for (int r = 0; r < 40; r++) begin
      rs = $urandom_range(8, 15);
      rc = $urandom_range(0, 6);
      for (int k = 0; k < 64; k++) src[k] = 1'($urandom_range(0, 1));
      model(rs, rc);
      start(rs[3:0], rc);
      drive(1'b1, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
